// File: rtl/siso_2cycles_pkg.sv
// Shared constants and helpers for the duty-cycle gated SISO register.
// Provides default sizing and the phase counter width function.
package siso_2cycles_pkg;

    localparam int N_DEF      = 4;
    localparam int PERIOD_DEF = 4;
    localparam int ACTIVE_DEF = 2;

    // Phase counter width: max(1, clog2(period)).
    function automatic int cnt_width(input int period);
        return (period > 2) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/siso_phase_cnt.sv
// Wrap-around frame phase counter with synchronous active-high reset.
// Ports: clk, rst in; phase_o (current phase), shift_en_o (phase < ACTIVE) out.
module siso_phase_cnt
    import siso_2cycles_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF,
    parameter int ACTIVE = ACTIVE_DEF,
    localparam int PW    = cnt_width(PERIOD)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [PW-1:0] phase_o,
    output logic          shift_en_o
);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Compare in int so ACTIVE == PERIOD == 2**PW does not truncate.
    always_comb begin
        phase_d = phase_q + PW'(1);
        if (int'(phase_q) == PERIOD - 1) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o    = phase_q;
    assign shift_en_o = (int'(phase_q) < ACTIVE);

endmodule

// File: rtl/siso_2cycles.sv
// Serial-in serial-out N-bit shift register that shifts only during the
// first ACTIVE clocks of every PERIOD-clock frame and holds otherwise.
// Ports: clk, rst (sync, active-high), I (serial in) -> F (serial out, MSB).
// Macro SISO_2CYCLES_SHIFT_VALID_EN adds output shift_valid (= shift enable).
module siso_2cycles
    import siso_2cycles_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int PERIOD = PERIOD_DEF,
    parameter int ACTIVE = ACTIVE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic I,
`ifdef SISO_2CYCLES_SHIFT_VALID_EN
    output logic shift_valid,
`endif
    output logic F
);

    localparam int PW = cnt_width(PERIOD);

    logic [PW-1:0] phase;
    logic          shift_en;
    logic [N-1:0]  sreg_q;
    logic [N-1:0]  sreg_d;

    siso_phase_cnt #(
        .PERIOD (PERIOD),
        .ACTIVE (ACTIVE)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .phase_o    (phase),
        .shift_en_o (shift_en)
    );

    // On hold edges the mux selects sreg_q, so I (even X) is ignored.
    generate
        if (N == 1) begin : g_n1
            always_comb begin
                sreg_d = shift_en ? I : sreg_q;
            end
        end else begin : g_nn
            always_comb begin
                sreg_d = shift_en ? {sreg_q[N-2:0], I} : sreg_q;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign F = sreg_q[N-1];

`ifdef SISO_2CYCLES_SHIFT_VALID_EN
    assign shift_valid = shift_en;
`endif

    phase_in_range: assert property (
        @(posedge clk) disable iff (rst) int'(phase) < PERIOD
    );

endmodule

// File: tb/tb_siso_2cycles.sv
// Scoreboard bench for siso_2cycles: directed scenarios plus random
// streams, checked against a frame-counting reference model.
module tb_siso_2cycles;

    localparam int N      = 4;
    localparam int PERIOD = 4;
    localparam int ACTIVE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic I   = 1'b0;
    logic F;
`ifdef SISO_2CYCLES_SHIFT_VALID_EN
    logic shift_valid;
`endif

    siso_2cycles #(
        .N      (N),
        .PERIOD (PERIOD),
        .ACTIVE (ACTIVE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .I           (I),
`ifdef SISO_2CYCLES_SHIFT_VALID_EN
        .shift_valid (shift_valid),
`endif
        .F           (F)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit f;
        bit sv;
    } exp_t;

    exp_t sb[$];
    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: frame position and the last N bits taken on
    // shift edges (oldest first, so the front is what F shows).
    int ph = 0;
    bit hist[$];

    always @(posedge clk) edges <= edges + 1;

    // Driver: sets inputs for the next edge and records what that
    // edge must produce.
    task automatic step(input bit r, input logic d);
        exp_t e;
        @(negedge clk);
        rst = r;
        I   = d;
        if (r) begin
            ph = 0;
            hist.delete();
            for (int k = 0; k < N; k++) hist.push_back(1'b0);
        end else begin
            if (ph < ACTIVE) begin
                hist.push_back(d === 1'b1);
                void'(hist.pop_front());
            end
            ph = (ph + 1) % PERIOD;
        end
        e.idx = edges + 1;
        e.f   = hist[0];
        e.sv  = (ph < ACTIVE);
        sb.push_back(e);
    endtask

    // Monitor: after each edge, compare outputs with the queued entry.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].idx <= edges) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (F !== e.f) begin
                errors++;
                $display("FAIL F edge %0d: got %b expected %b",
                         e.idx, F, e.f);
            end
`ifdef SISO_2CYCLES_SHIFT_VALID_EN
            checks++;
            if (shift_valid !== e.sv) begin
                errors++;
                $display("FAIL shift_valid edge %0d: got %b expected %b",
                         e.idx, shift_valid, e.sv);
            end
`endif
        end
    end

    task automatic do_reset(input int n, input logic d);
        for (int k = 0; k < n; k++) step(1'b1, d);
    endtask

    initial begin
        // Reset with I=1, then constant ones: F rises after edge 6.
        do_reset(2, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1);

        // Single pulse at edge 1: F high after edges 6..8 only.
        do_reset(1, 1'b0);
        step(1'b0, 1'b1);
        for (int k = 0; k < 14; k++) step(1'b0, 1'b0);

        // Hold immunity: I toggles or is X only on hold phases.
        do_reset(1, 1'b0);
        for (int k = 0; k < 24; k++) begin
            if ((k % PERIOD) < ACTIVE) step(1'b0, 1'b0);
            else if (k % 3 == 0) step(1'b0, 1'bx);
            else step(1'b0, logic'(k[0]));
        end

        // Mid-frame reset at phase 2 with sreg = 1111.
        do_reset(1, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1);

        // Random 32-bit streams, one bit per clock, rare resets.
        for (int r = 0; r < 6; r++) begin
            logic [31:0] w;
            w = $urandom;
            do_reset(1 + (r % 2), logic'($urandom_range(0, 1)));
            for (int k = 0; k < 32; k++) begin
                step($urandom_range(0, 40) == 0, w[k]);
            end
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 8 && sb.size() > 0; k++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/siso_2cycles.md
Name: siso_2cycles

Overview:
- Serial-in serial-out N-bit shift register with a built-in duty-cycle gate.
- A free-running phase counter divides time into frames of PERIOD clocks. The register shifts only during the first ACTIVE clocks of each frame and holds for the remaining clocks.
- Defaults give shifting on 2 of every 4 clocks.
- Used as a rate-gated serial delay line between a serial source and sink in the same clock domain.

Parameters:
- N, 4, shift register depth in bits; legal N >= 1.
- PERIOD, 4, frame length in clocks; legal PERIOD >= 1.
- ACTIVE, 2, number of shifting clocks at the start of each frame; legal 1 <= ACTIVE <= PERIOD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- I  input  1  serial data in; sampled only on shift edges.
- F  output  1  serial data out; equals the MSB (bit N-1) of the register.

Behaviour:
- One clock; reset is synchronous and active-high.
- State:
  - sreg[N-1:0].
  - phase counter, width max(1, clog2(PERIOD)).
- Reset (rst=1 at a rising edge): sreg <= 0, phase <= 0, so F=0. Reset overrides shifting. Reset mid-frame restarts the frame at phase 0 on the next edge.
- Phase: at each non-reset edge, phase <= (phase == PERIOD-1) ? 0 : phase+1. It wraps with no gap.
- Shift enable: shift_en = (phase < ACTIVE), evaluated on the pre-edge phase value. The first ACTIVE edges after reset release are shift edges.
- Shift edge: sreg <= {sreg[N-2:0], I}. When N=1, sreg <= I.
- Hold edge: sreg unchanged; I is ignored.
- F = sreg[N-1], registered, with no combinational path from I.
- Latency: a bit sampled on a shift edge reaches F after exactly N shift edges, not N clock edges.
  - Defaults: a bit sampled at edge 1 appears on F after edge 6.
- When ACTIVE == PERIOD, the block degenerates to a plain SISO register that shifts every clock.
- X on I during hold edges must not propagate.

Optional Feature:
- Macro SISO_2CYCLES_SHIFT_VALID_EN.
- Defined: adds output port shift_valid (1 bit), combinationally equal to shift_en. It is 1 during phases 0..ACTIVE-1 and is 1 while rst=1, because phase is held at 0 during reset.
- Undefined: the port does not exist; no other behavioural change.

Decomposition:
- Package siso_2cycles_pkg:
  - default constants N_DEF=4, PERIOD_DEF=4, ACTIVE_DEF=2;
  - a function computing the counter width.
- One natural sub-module, siso_phase_cnt: a parameterized wrap-around counter with synchronous reset, outputting phase and shift_en.
- The top module holds sreg and instantiates siso_phase_cnt.

Test Plan:
- Reset: rst=1 for 2 edges with I=1 -> F=0, phase=0; release rst -> first two edges shift.
- Constant I=1 from release, defaults -> sreg 0001, 0011, 0011, 0011, 0111, 1111 after edges 1..6; F rises after edge 6.
- Single pulse: I=1 only at edge 1, else 0 -> F=1 after edge 6, F returns to 0 after edge 9; F is 1 for exactly 3 clocks.
- Hold immunity: toggle I only on phases 2 and 3 (edges 3,4,7,8), I=0 otherwise -> F stays 0 forever.
- Mid-frame reset: load sreg=1111, assert rst for one edge while phase=2 -> F=0 next cycle; the following two edges shift.
- Random 32-bit I stream, one sample per clock -> F matches a reference model shifting only on phases 0,1; with the macro defined, shift_valid pattern is 1,1,0,0 repeating.
